// File: rtl/pipe_pkg.sv
// Shared pipeline codes: sequencer states, redirect kinds,
// default reset and exception vectors.
package pipe_pkg;

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  typedef enum logic [1:0] {
    S_BOOT = ST_BOOT,
    S_RUN  = ST_RUN,
    S_WAIT = ST_WAIT
  } state_t;

  // Numeric order doubles as redirect priority.
  localparam logic [1:0] RK_NONE = 2'd0;
  localparam logic [1:0] RK_JMP  = 2'd1;
  localparam logic [1:0] RK_BR   = 2'd2;
  localparam logic [1:0] RK_EXC  = 2'd3;

  localparam logic [31:0] RESET_VEC_DEF = 32'h0000_0000;
  localparam logic [31:0] EXC_VEC_DEF   = 32'h0000_0180;

endpackage

// File: rtl/redirect_pending.sv
// Holds the strongest redirect seen while imem is busy
// until the first ready cycle consumes it.
module redirect_pending
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        ev_kind,
  input  logic [ADDR_W-1:0] ev_target,
  input  logic              ld,
  input  logic              clr,
  output logic [1:0]        pend_kind,
  output logic [ADDR_W-1:0] pend_target,
  output logic              live_wins
);

  assign live_wins = (ev_kind != RK_NONE) &&
                     (ev_kind >= pend_kind);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_kind   <= RK_NONE;
      pend_target <= '0;
    end else if (clr) begin
      pend_kind   <= RK_NONE;
    end else if (ld && live_wins) begin
      pend_kind   <= ev_kind;
      pend_target <= ev_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Next-PC selection, fetch handshake and flush generation
// for the 5-stage pipeline.
module pc_sequencer
  import pipe_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_DEF),
  parameter logic [ADDR_W-1:0] EXC_VEC   = ADDR_W'(EXC_VEC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_cur,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jmp,
  input  logic [ADDR_W-1:0] jmp_target,
  input  logic              exc,
  input  logic              imem_ready,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic              if_valid,
  output logic              flush_if,
  output logic              flush_id
);

  state_t            state;
  state_t            nstate;
  logic [1:0]        live_kind;
  logic [ADDR_W-1:0] live_tgt;
  logic [1:0]        pend_kind;
  logic [ADDR_W-1:0] pend_tgt;
  logic              live_wins;
  logic              pend_ld;
  logic              pend_clr;
  logic              has_pend;
  logic              hold;

  always_comb begin
    live_kind = RK_NONE;
    live_tgt  = jmp_target;
    unique case (1'b1)
      exc: begin
        live_kind = RK_EXC;
        live_tgt  = EXC_VEC;
      end
      (!exc && br_taken): begin
        live_kind = RK_BR;
        live_tgt  = br_target;
      end
      (!exc && !br_taken && jmp): begin
        live_kind = RK_JMP;
        live_tgt  = jmp_target;
      end
      default: ;
    endcase
  end

  redirect_pending #(
    .ADDR_W(ADDR_W)
  ) u_pend (
    .clk        (clk),
    .rst        (rst),
    .ev_kind    (live_kind),
    .ev_target  (live_tgt),
    .ld         (pend_ld),
    .clr        (pend_clr),
    .pend_kind  (pend_kind),
    .pend_target(pend_tgt),
    .live_wins  (live_wins)
  );

  assign has_pend = (pend_kind != RK_NONE);
  // WAIT completing with nothing to apply re-issues pc_cur.
  assign hold     = (state == S_WAIT) || stall;

  always_comb begin
    nstate   = state;
    pc_next  = pc_cur;
    imem_req = 1'b0;
    if_valid = 1'b0;
    flush_if = 1'b0;
    flush_id = 1'b0;
    pend_ld  = 1'b0;
    pend_clr = 1'b0;
    unique case (state)
      S_RUN, S_WAIT: begin
        imem_req = 1'b1;
        if (!imem_ready) begin
          nstate   = S_WAIT;
          pend_ld  = 1'b1;
          flush_if = (live_kind != RK_NONE);
          flush_id = (live_kind >= RK_BR);
        end else begin
          nstate   = S_RUN;
          pend_clr = 1'b1;
          unique case (1'b1)
            live_wins: begin
              pc_next  = live_tgt;
              flush_if = 1'b1;
              flush_id = (live_kind >= RK_BR);
            end
            (!live_wins && has_pend): begin
              pc_next  = pend_tgt;
              flush_if = 1'b1;
            end
            (!live_wins && !has_pend && hold): begin
              pc_next  = pc_cur;
            end
            default: begin
              pc_next  = pc_cur + ADDR_W'(4);
              if_valid = 1'b1;
            end
          endcase
        end
      end
      default: begin
        nstate  = S_RUN;
        pc_next = RESET_VEC;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_BOOT;
    else      state <= nstate;
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and random checks of pc_sequencer against a
// cycle-level reference model of the next-PC rules.
module tb_pc_sequencer;

  localparam logic [31:0] RVEC = 32'h0000_0000;
  localparam logic [31:0] EVEC = 32'h0000_0180;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_cur = '0;
  logic        stall = 1'b0;
  logic        br_taken = 1'b0;
  logic [31:0] br_target = '0;
  logic        jmp = 1'b0;
  logic [31:0] jmp_target = '0;
  logic        exc = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] pc_next;
  logic        imem_req;
  logic        if_valid;
  logic        flush_if;
  logic        flush_id;

  int total = 0;
  int bad = 0;

  bit          m_boot;
  bit          m_wait;
  int          m_pk;
  logic [31:0] m_pt;
  logic [31:0] pc;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .pc_cur    (pc_cur),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_target (br_target),
    .jmp       (jmp),
    .jmp_target(jmp_target),
    .exc       (exc),
    .imem_ready(imem_ready),
    .pc_next   (pc_next),
    .imem_req  (imem_req),
    .if_valid  (if_valid),
    .flush_if  (flush_if),
    .flush_id  (flush_id)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_boot = 1'b1;
    m_wait = 1'b0;
    m_pk   = 0;
    m_pt   = '0;
    pc     = RVEC;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".pc"},  pc_next,  RVEC);
    check({tag, ".req"}, {31'b0, imem_req}, 32'd0);
    check({tag, ".ifv"}, {31'b0, if_valid}, 32'd0);
    check({tag, ".fi"},  {31'b0, flush_if}, 32'd0);
    check({tag, ".fd"},  {31'b0, flush_id}, 32'd0);
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input logic [31:0] pcv, input bit st,
                      input bit b, input logic [31:0] bt,
                      input bit j, input logic [31:0] jt,
                      input bit e, input bit r,
                      input string tag);
    logic [31:0] xp;
    logic [31:0] lt;
    bit xq, xv, xfi, xfd;
    int lp;
    pc_cur = pcv; stall = st;
    br_taken = b; br_target = bt;
    jmp = j; jmp_target = jt;
    exc = e; imem_ready = r;
    #3;
    lp = e ? 3 : (b ? 2 : (j ? 1 : 0));
    lt = e ? EVEC : (b ? bt : jt);
    xp = pcv; xq = 0; xv = 0; xfi = 0; xfd = 0;
    if (m_boot) begin
      xp = RVEC;
      m_boot = 1'b0;
    end else begin
      xq = 1;
      if (!r) begin
        xfi = (lp > 0);
        xfd = (lp > 1);
        if (lp > 0 && lp >= m_pk) begin
          m_pk = lp;
          m_pt = lt;
        end
        m_wait = 1'b1;
      end else begin
        if (lp > 0 && lp >= m_pk) begin
          xp = lt; xfi = 1; xfd = (lp > 1);
        end else if (m_pk > 0) begin
          xp = m_pt; xfi = 1;
        end else if (!m_wait && !st) begin
          xp = pcv + 32'd4; xv = 1;
        end
        m_pk = 0;
        m_wait = 1'b0;
      end
    end
    check({tag, ".pc"},  pc_next, xp);
    check({tag, ".req"}, {31'b0, imem_req}, {31'b0, xq});
    check({tag, ".ifv"}, {31'b0, if_valid}, {31'b0, xv});
    check({tag, ".fi"},  {31'b0, flush_if}, {31'b0, xfi});
    check({tag, ".fd"},  {31'b0, flush_id}, {31'b0, xfd});
    pc = xp;
    @(posedge clk);
    #1;
  endtask

  task automatic quiet(input logic [31:0] pcv, input bit r,
                       input string tag);
    step(pcv, 0, 0, '0, 0, '0, 0, r, tag);
  endtask

  initial begin
    model_reset();
    #1;
    check_reset_outputs("por");
    @(posedge clk); #1;
    rst = 1'b1;

    quiet(pc, 1, "boot");
    for (int i = 0; i < 3; i++) quiet(pc, 1, "seq");
    check("seq.pc12", pc, 32'd12);

    step(32'h40, 0, 1, 32'h100, 1, 32'h300, 0, 1, "brjmp");
    for (int i = 0; i < 3; i++)
      step(32'h40, 1, 0, '0, 0, '0, 0, 1, "stall");
    step(32'h40, 1, 0, '0, 0, '0, 1, 1, "stallexc");

    step(32'h20, 0, 0, '0, 1, 32'h80, 0, 0, "wjmp");
    step(32'h20, 0, 1, 32'h200, 0, '0, 0, 0, "wbr");
    step(32'h20, 0, 0, '0, 1, 32'h500, 0, 1, "wdone");
    check("wdone.tgt", pc, 32'h200);
    quiet(32'h200, 1, "wclr");

    step(32'h60, 0, 1, 32'h300, 0, '0, 0, 0, "lowpri");
    step(32'h60, 0, 0, '0, 1, 32'h90, 0, 1, "lowpri2");
    quiet(32'hFFFF_FFFC, 1, "wrap");
    check("wrap.val", pc, 32'h0);

    step(32'h30, 0, 0, '0, 0, '0, 1, 0, "rwait");
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    quiet(pc, 1, "rboot");
    quiet(pc, 1, "rrun");

    for (int i = 0; i < 3000; i++) begin
      logic [31:0] pv;
      pv = ($urandom_range(0, 4) == 0) ? $urandom() : pc;
      step(pv,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 7) == 0, $urandom(),
           $urandom_range(0, 7) == 0, $urandom(),
           $urandom_range(0, 15) == 0,
           $urandom_range(0, 3) != 0,
           "rnd");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
